// File: rtl/eth_idma_reg_frontend.sv
// -----------------------------------------------------------------------------
// eth_idma_reg_frontend
//
// Purpose:
//   Terminates the 32-bit configuration bus of an Ethernet iDMA wrapper. Holds
//   the MAC address/config and one transfer descriptor. Software writes are
//   turned into an iDMA valid/ready request handshake. iDMA responses are
//   captured into sticky, readable status and an interrupt pulse.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   reg_*                      register bus (always ready, combinational read)
//   idma_req_valid_o/ready_i   request handshake towards the iDMA
//   idma_src/dst_addr_o,
//   idma_length_o,
//   idma_src/dst_protocol_o    descriptor payload (stable while valid is high)
//   idma_rsp_valid_i/ready_o,
//   idma_rsp_error_i           response handshake from the iDMA
//   mac_addr_o, mac_cfg_o      MAC address and MAC configuration
//   irq_o                      one-cycle pulse per accepted response
// -----------------------------------------------------------------------------
module eth_idma_reg_frontend #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_valid_i,
  input  logic                  reg_write_i,
  input  logic [31:0]           reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  input  logic [3:0]            reg_wstrb_i,
  output logic                  reg_ready_o,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_error_o,
  output logic                  idma_req_valid_o,
  input  logic                  idma_req_ready_i,
  output logic [AddrWidth-1:0]  idma_src_addr_o,
  output logic [AddrWidth-1:0]  idma_dst_addr_o,
  output logic [TFLenWidth-1:0] idma_length_o,
  output logic [2:0]            idma_src_protocol_o,
  output logic [2:0]            idma_dst_protocol_o,
  input  logic                  idma_rsp_valid_i,
  output logic                  idma_rsp_ready_o,
  input  logic                  idma_rsp_error_i,
  output logic [47:0]           mac_addr_o,
  output logic [15:0]           mac_cfg_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  // Word indices (byte offset >> 2)
  localparam logic [4:0] IdxMacLo     = 5'h00;
  localparam logic [4:0] IdxMacHi     = 5'h01;
  localparam logic [4:0] IdxSrc       = 5'h04;
  localparam logic [4:0] IdxDst       = 5'h05;
  localparam logic [4:0] IdxLen       = 5'h06;
  localparam logic [4:0] IdxSrcProt   = 5'h07;
  localparam logic [4:0] IdxDstProt   = 5'h08;
  localparam logic [4:0] IdxReqValid  = 5'h0E;
  localparam logic [4:0] IdxReqReady  = 5'h0F;
  localparam logic [4:0] IdxRspReady  = 5'h10;
  localparam logic [4:0] IdxRspValid  = 5'h11;
  localparam logic [4:0] IdxStatus    = 5'h12;
  localparam logic [4:0] IdxStatusClr = 5'h13;

  localparam logic [3:0] OutMax = 4'(MaxOutstanding);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] maclo_q, maclo_d;
  logic [31:0] machi_q, machi_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [2:0]  src_prot_q, src_prot_d;
  logic [2:0]  dst_prot_q, dst_prot_d;
  logic        rsp_ready_q, rsp_ready_d;
  state_e      state_q, state_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        last_err_q, last_err_d;
  logic        err_sticky_q, err_sticky_d;
  logic [15:0] done_count_q, done_count_d;
  logic        irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [4:0]  idx;
  logic        addr_known;
  logic        addr_ro;
  logic        wr_ok;
  logic [31:0] wmask;

  assign idx = reg_addr_i[6:2];

  // Upper and sub-word address bits are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{reg_addr_i[31:7], reg_addr_i[1:0]};

  always_comb begin
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (idx)
      IdxMacLo, IdxMacHi, IdxSrc, IdxDst, IdxLen, IdxSrcProt, IdxDstProt,
      IdxReqValid, IdxRspReady, IdxStatusClr: addr_ro = 1'b0;
      IdxReqReady, IdxRspValid, IdxStatus:    addr_ro = 1'b1;
      default:                                addr_known = 1'b0;
    endcase
  end

  // Byte-lane write mask from the strobes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{reg_wstrb_i[gi]}};
  end

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign wr_ok = reg_valid_i & reg_write_i & addr_known & ~addr_ro;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic req_hs;
  logic rsp_hs;
  logic can_launch;
  logic reqv_wr;
  logic desc_wr_ok;
  logic clr_wr;
  logic drop_req;
  logic [31:0] prot_src_merged;
  logic [31:0] prot_dst_merged;

  assign req_hs     = (state_q == ST_REQ) & idma_req_ready_i;
  assign rsp_hs     = idma_rsp_valid_i & rsp_ready_q;
  assign can_launch = (outstanding_q < OutMax);
  assign reqv_wr    = wr_ok & (idx == IdxReqValid) & reg_wstrb_i[0];
  assign clr_wr     = wr_ok & (idx == IdxStatusClr);
  // The descriptor is frozen while a request is being offered.
  assign desc_wr_ok = wr_ok & (state_q != ST_REQ);

  assign prot_src_merged = merge({29'd0, src_prot_q}, reg_wdata_i, wmask);
  assign prot_dst_merged = merge({29'd0, dst_prot_q}, reg_wdata_i, wmask);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    maclo_d       = maclo_q;
    machi_d       = machi_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    src_prot_d    = src_prot_q;
    dst_prot_d    = dst_prot_q;
    rsp_ready_d   = rsp_ready_q;
    state_d       = state_q;
    outstanding_d = outstanding_q;
    last_err_d    = last_err_q;
    err_sticky_d  = err_sticky_q;
    done_count_d  = done_count_q;
    irq_d         = rsp_hs;
    drop_req      = 1'b0;

    // Plain configuration registers
    if (wr_ok && idx == IdxMacLo) maclo_d = merge(maclo_q, reg_wdata_i, wmask);
    if (wr_ok && idx == IdxMacHi) machi_d = merge(machi_q, reg_wdata_i, wmask);
    if (wr_ok && idx == IdxRspReady && reg_wstrb_i[0]) rsp_ready_d = reg_wdata_i[0];

    // Descriptor registers
    if (desc_wr_ok && idx == IdxSrc)     src_d      = merge(src_q, reg_wdata_i, wmask);
    if (desc_wr_ok && idx == IdxDst)     dst_d      = merge(dst_q, reg_wdata_i, wmask);
    if (desc_wr_ok && idx == IdxLen)     len_d      = merge(len_q, reg_wdata_i, wmask);
    if (desc_wr_ok && idx == IdxSrcProt) src_prot_d = prot_src_merged[2:0];
    if (desc_wr_ok && idx == IdxDstProt) dst_prot_d = prot_dst_merged[2:0];

    // Request FSM. REQ ignores REQ_VALID writes so the offer cannot be
    // withdrawn mid-handshake; LOCK waits for software to write 0 so a stale
    // 1 never launches a second transfer.
    case (state_q)
      ST_IDLE: begin
        if (reqv_wr && reg_wdata_i[0]) begin
          if (can_launch) state_d = ST_REQ;
          else            drop_req = 1'b1;
        end
      end
      ST_REQ: begin
        if (req_hs) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (reqv_wr && !reg_wdata_i[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outstanding counter. A response with nothing outstanding does not
    // underflow; a launch and a retire in the same cycle cancel.
    case ({req_hs, rsp_hs && (outstanding_q != 4'd0)})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // W1C clears are applied first so an event in the same cycle survives.
    // Clearing the error flags drops last_err together with err_sticky.
    if (clr_wr && reg_wstrb_i[0] && reg_wdata_i[1]) begin
      err_sticky_d = 1'b0;
      last_err_d   = 1'b0;
    end
    if (clr_wr && reg_wstrb_i[1] && reg_wdata_i[8]) done_count_d = 16'd0;

    if (rsp_hs) begin
      last_err_d = idma_rsp_error_i;
      if (idma_rsp_error_i || outstanding_q == 4'd0) err_sticky_d = 1'b1;
      if (done_count_d != 16'hFFFF) done_count_d = done_count_d + 16'd1;
    end
    if (drop_req) err_sticky_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      maclo_q       <= '0;
      machi_q       <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      src_prot_q    <= '0;
      dst_prot_q    <= '0;
      rsp_ready_q   <= 1'b0;
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      last_err_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
      done_count_q  <= '0;
      irq_q         <= 1'b0;
    end else begin
      maclo_q       <= maclo_d;
      machi_q       <= machi_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      len_q         <= len_d;
      src_prot_q    <= src_prot_d;
      dst_prot_q    <= dst_prot_d;
      rsp_ready_q   <= rsp_ready_d;
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      last_err_q    <= last_err_d;
      err_sticky_q  <= err_sticky_d;
      done_count_q  <= done_count_d;
      irq_q         <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata_o = 32'd0;
    case (idx)
      IdxMacLo:    reg_rdata_o = maclo_q;
      IdxMacHi:    reg_rdata_o = machi_q;
      IdxSrc:      reg_rdata_o = src_q;
      IdxDst:      reg_rdata_o = dst_q;
      IdxLen:      reg_rdata_o = len_q;
      IdxSrcProt:  reg_rdata_o = {29'd0, src_prot_q};
      IdxDstProt:  reg_rdata_o = {29'd0, dst_prot_q};
      IdxReqValid: reg_rdata_o = {31'd0, state_q != ST_IDLE};
      IdxReqReady: reg_rdata_o = {31'd0, (state_q == ST_IDLE) && can_launch};
      IdxRspReady: reg_rdata_o = {31'd0, rsp_ready_q};
      IdxRspValid: reg_rdata_o = {31'd0, idma_rsp_valid_i};
      IdxStatus:   reg_rdata_o = {8'd0, done_count_q, outstanding_q, 2'd0,
                                  err_sticky_q, last_err_q};
      default:     reg_rdata_o = 32'd0;
    endcase
  end

  assign reg_ready_o = 1'b1;
  assign reg_error_o = reg_valid_i & (~addr_known | (reg_write_i & addr_ro));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign idma_req_valid_o    = (state_q == ST_REQ);
  assign idma_src_addr_o     = AddrWidth'(src_q);
  assign idma_dst_addr_o     = AddrWidth'(dst_q);
  assign idma_length_o       = TFLenWidth'(len_q);
  assign idma_src_protocol_o = src_prot_q;
  assign idma_dst_protocol_o = dst_prot_q;
  assign idma_rsp_ready_o    = rsp_ready_q;
  assign mac_addr_o          = {machi_q[15:0], maclo_q};
  assign mac_cfg_o           = machi_q[31:16];
  assign irq_o               = irq_q;

endmodule
